t80_seq_div: RTL and testbench

- Iterative unsigned restoring divider for the T80/Game Boy CPU support logic.
- It is the inverse counterpart of the combinational add/subtract path: each step is one trial subtraction, done as A + ~B + 1, with the carry-out acting as the no-borrow flag.
- It produces one quotient bit per clock and presents its result over a start/busy/done handshake.
- It sits beside the ALU and serves multi-cycle extended arithmetic operations.

---
 rtl/t80_seq_div.sv | 118 +++++++++++
 tb/tb_t80_seq_div.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/t80_seq_div.sv
`default_nettype none
// ============================================================================
// Module   : t80_seq_div
// Purpose  : Iterative unsigned restoring divider used beside the T80 ALU for
//            multi-cycle extended arithmetic. One quotient bit per clock; each
//            step is a trial subtraction A + ~B + 1 whose carry-out is the
//            no-borrow flag.
// Ports    : clk        - system clock, rising edge
//            reset      - asynchronous, active-high reset
//            start      - division request, sampled only while not busy
//            dividend   - numerator, captured on the accepting edge
//            divisor    - denominator, captured on the accepting edge
//            busy       - high while iterations are in progress
//            done       - one-cycle pulse, results valid
//            quotient   - result quotient, held until the next completion
//            remainder  - result remainder, held until the next completion
//            div_zero   - divisor was zero, held with the results
// Revision : 1.0 - initial release
// ============================================================================
module t80_seq_div #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] p_reg;   // partial remainder
  logic [WIDTH-1:0] q_reg;   // dividend shifter, fills with quotient bits
  logic [WIDTH-1:0] d_reg;   // captured divisor

  logic [WIDTH:0]   trial;   // shifted partial remainder
  logic [WIDTH+1:0] sum;     // trial + ~{0,d} + 1
  logic             nb;      // no-borrow: trial >= divisor
  logic [WIDTH-1:0] p_next;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    trial = {p_reg, q_reg[WIDTH-1]};
    sum   = {1'b0, trial} + {1'b0, ~{1'b0, d_reg}} + {{(WIDTH+1){1'b0}}, 1'b1};
    // Since p_reg < d_reg always holds, a successful trial leaves a difference
    // below d_reg, so bit WIDTH of the sum is zero whenever the carry is set.
    // Requiring it keeps the partial remainder strictly WIDTH bits wide.
    nb     = sum[WIDTH+1] & ~sum[WIDTH];
    p_next = nb ? sum[WIDTH-1:0] : trial[WIDTH-1:0];
    q_next = {q_reg[WIDTH-2:0], nb};
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      count     <= '0;
      p_reg     <= '0;
      q_reg     <= '0;
      d_reg     <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (divisor != '0) begin
              d_reg <= divisor;
              q_reg <= dividend;
              p_reg <= '0;
              count <= CW'(WIDTH - 1);
              state <= S_RUN;
            end else begin
              // Divide by zero completes immediately without iterating.
              quotient  <= '1;
              remainder <= dividend;
              div_zero  <= 1'b1;
              state     <= S_DONE;
            end
          end else begin
            state <= S_IDLE;
          end
        end
        S_RUN: begin
          p_reg <= p_next;
          q_reg <= q_next;
          if (count == '0) begin
            // Result registers and the zero flag only move on completion so
            // the previous result stays visible throughout the run.
            quotient  <= q_next;
            remainder <= p_next;
            div_zero  <= 1'b0;
            state     <= S_DONE;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_t80_seq_div.sv
`default_nettype none
// ============================================================================
// Module   : tb_t80_seq_div
// Purpose  : Directed self-checking bench for t80_seq_div, one 8-bit and one
//            16-bit instance sharing clock and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_t80_seq_div;

  logic        clk = 1'b0;
  logic        reset;

  logic        start8;
  logic [7:0]  dividend8, divisor8, q8, r8;
  logic        busy8, done8, dz8;

  logic        start16;
  logic [15:0] dividend16, divisor16, q16, r16;
  logic        busy16, done16, dz16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  t80_seq_div #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8),
    .dividend(dividend8), .divisor(divisor8),
    .busy(busy8), .done(done8),
    .quotient(q8), .remainder(r8), .div_zero(dz8)
  );

  t80_seq_div #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16),
    .dividend(dividend16), .divisor(divisor16),
    .busy(busy16), .done(done16),
    .quotient(q16), .remainder(r16), .div_zero(dz16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete 8-bit division from an idle divider.
  task automatic do_div8(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] eq, input logic [7:0] er, input logic edz);
    int n;
    int bcnt;
    logic [7:0] pq;
    logic hold_ok;
    pq = q8;
    hold_ok = 1'b1;
    start8 = 1'b1;
    dividend8 = a;
    divisor8 = b;
    tick();
    start8 = 1'b0;
    dividend8 = 8'hC3;
    divisor8 = 8'h11;
    n = 0;
    bcnt = 0;
    while (!done8 && n < 40) begin
      if (busy8) bcnt++;
      if (q8 !== pq) hold_ok = 1'b0;
      tick();
      n++;
    end
    check({tag, " latency"}, n, (b == 8'd0) ? 0 : 8);
    check({tag, " busy_cycles"}, bcnt, (b == 8'd0) ? 0 : 8);
    check({tag, " busy_at_done"}, busy8, 0);
    check({tag, " quotient"}, q8, eq);
    check({tag, " remainder"}, r8, er);
    check({tag, " div_zero"}, dz8, edz);
    check({tag, " held_while_busy"}, hold_ok, 1);
    tick();
    check({tag, " done_one_cycle"}, done8, 0);
  endtask

  initial begin
    int n;
    int pulses;
    logic [7:0] cq, cr;

    reset = 1'b1;
    start8 = 1'b0;  dividend8 = '0;  divisor8 = '0;
    start16 = 1'b0; dividend16 = '0; divisor16 = '0;
    tick();
    tick();
    check("reset busy", busy8, 0);
    check("reset done", done8, 0);
    check("reset quotient", q8, 0);
    check("reset remainder", r8, 0);
    check("reset div_zero", dz8, 0);
    check("reset16 busy", busy16, 0);
    check("reset16 quotient", q16, 0);
    reset = 1'b0;
    tick();

    do_div8("100/7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
    do_div8("255/1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
    do_div8("5/9", 8'd5, 8'd9, 8'd0, 8'd5, 1'b0);
    do_div8("255/255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
    do_div8("0/3", 8'd0, 8'd3, 8'd0, 8'd0, 1'b0);
    do_div8("5A/0", 8'h5A, 8'd0, 8'hFF, 8'h5A, 1'b1);
    do_div8("6/3", 8'd6, 8'd3, 8'd2, 8'd0, 1'b0);

    // start during RUN must be ignored
    start8 = 1'b1; dividend8 = 8'd200; divisor8 = 8'd13;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    start8 = 1'b1; dividend8 = 8'd9; divisor8 = 8'd2;
    tick();
    start8 = 1'b0;
    pulses = 0;
    cq = '0;
    cr = '0;
    for (int i = 0; i < 20; i++) begin
      if (done8) begin
        pulses++;
        cq = q8;
        cr = r8;
      end
      tick();
    end
    check("ignore pulses", pulses, 1);
    check("ignore quotient", cq, 15);
    check("ignore remainder", cr, 5);

    // asynchronous reset between edges in the middle of a run
    start8 = 1'b1; dividend8 = 8'd200; divisor8 = 8'd13;
    tick();
    start8 = 1'b0;
    tick();
    tick();
    #3;
    reset = 1'b1;
    #1;
    check("async busy", busy8, 0);
    check("async done", done8, 0);
    check("async quotient", q8, 0);
    check("async remainder", r8, 0);
    check("async div_zero", dz8, 0);
    tick();
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done8 || busy8) pulses++;
      tick();
    end
    check("after reset quiet", pulses, 0);
    do_div8("60/4", 8'd60, 8'd4, 8'd15, 8'd0, 1'b0);

    // back-to-back: start held through the done cycle
    start8 = 1'b1; dividend8 = 8'd100; divisor8 = 8'd7;
    tick();
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 40) begin
      tick();
      n++;
    end
    check("b2b first done", done8, 1);
    check("b2b first quotient", q8, 14);
    start8 = 1'b1; dividend8 = 8'd77; divisor8 = 8'd10;
    tick();
    check("b2b busy at accept", busy8, 1);
    check("b2b no done at accept", done8, 0);
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 40) begin
      tick();
      n++;
    end
    check("b2b latency", n, 8);
    check("b2b quotient", q8, 7);
    check("b2b remainder", r8, 7);

    // 16-bit instance
    start16 = 1'b1; dividend16 = 16'd65535; divisor16 = 16'd256;
    tick();
    start16 = 1'b0;
    n = 0;
    while (!done16 && n < 60) begin
      tick();
      n++;
    end
    check("w16 latency", n, 16);
    check("w16 quotient", q16, 255);
    check("w16 remainder", r16, 255);
    check("w16 div_zero", dz16, 0);
    tick();
    check("w16 done one cycle", done16, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
